// File: rtl/schur_eig_extract.sv
// Eigenvalue extraction from an NxN real Schur-form matrix: walks the diagonal,
// resolves 1x1 and 2x2 blocks, and streams eigenvalues over valid/ready.
module schur_eig_extract #(
  parameter int N    = 4,
  parameter int W    = 16,
  parameter int FRAC = 8,
  parameter int TOL  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N*N*W-1:0]       a_mat,
  output logic                   busy,
  output logic                   done,
  output logic                   eig_valid,
  input  logic                   eig_ready,
  output logic [W-1:0]           eig_re,
  output logic [W-1:0]           eig_im,
  output logic [$clog2(N)-1:0]   eig_idx,
  output logic                   eig_cplx,
  output logic                   malformed
);

  localparam int IW = $clog2(N);
  localparam int KW = $clog2(N + 2);
  localparam int DW = 2 * W + 2;
  localparam int RW = W + 4;
  localparam int CW = $clog2(W + 1);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [KW-1:0] K_END  = KW'(N);
  localparam logic [W:0]    TOL_V  = (W + 1)'(TOL);
  localparam logic [W-1:0]  S_MAX  = {1'b0, {(W - 1){1'b1}}};
  localparam logic [W-1:0]  S_MIN  = {1'b1, {(W - 1){1'b0}}};

  if (N < 2 || FRAC < 0 || FRAC >= W) begin : g_param_check
    $error("schur_eig_extract: need N >= 2 and 0 <= FRAC < W");
  end

  typedef enum logic [2:0] {IDLE, SCAN, CALC, SQRT, EMIT1, EMIT2, FIN} state_t;
  state_t state_reg, state_next;

  logic [N*N*W-1:0]      a_reg;
  logic signed [W-1:0]   a_arr [N][N];
  logic [KW-1:0]         k_reg;
  logic [IW-1:0]         idx_reg;
  logic                  pair_reg, neg_reg, malformed_reg;
  logic signed [W-1:0]   blk_a_reg, blk_b_reg, blk_c_reg, blk_d_reg;
  logic signed [W:0]     m_reg;
  logic [DW-1:0]         rad_reg;
  logic [RW-1:0]         rem_reg;
  logic [W:0]            root_reg;
  logic [CW-1:0]         cnt_reg;
  logic [W-1:0]          eig_re_reg, eig_im_reg, re2_reg, im2_reg;
  logic [IW-1:0]         eig_idx_reg;
  logic                  eig_cplx_reg;

  genvar gi;
  for (gi = 0; gi < N * N; gi++) begin : g_unpack
    assign a_arr[gi / N][gi % N] = a_reg[gi * W +: W];
  end

  function automatic logic [W:0] mag(input logic signed [W-1:0] x);
    logic signed [W:0] xe;
    xe = {x[W-1], x};
    return xe[W] ? -xe : xe;
  endfunction

  function automatic logic [W-1:0] sat(input logic [W+1:0] x);
    if (x[W+1:W-1] == 3'b000 || x[W+1:W-1] == 3'b111) return x[W-1:0];
    else if (x[W+1]) return S_MIN;
    else return S_MAX;
  endfunction

  // Elements around the current diagonal position; indices clamp at the last row.
  logic signed [W-1:0] akk, akk1, ak1k, ak1k1, ak2k1;
  always_comb begin
    akk = '0; akk1 = '0; ak1k = '0; ak1k1 = '0; ak2k1 = '0;
    for (int i = 0; i < N; i++) begin
      if (k_reg == KW'(i)) begin
        akk   = a_arr[i][i];
        akk1  = a_arr[i][(i + 1 < N) ? i + 1 : i];
        ak1k  = a_arr[(i + 1 < N) ? i + 1 : i][i];
        ak1k1 = a_arr[(i + 1 < N) ? i + 1 : i][(i + 1 < N) ? i + 1 : i];
        ak2k1 = a_arr[(i + 2 < N) ? i + 2 : i][(i + 1 < N) ? i + 1 : i];
      end
    end
  end

  logic single, mal_hit, xfer, more, sqrt_last;
  assign single    = (k_reg == K_LAST) || (mag(ak1k) <= TOL_V);
  assign mal_hit   = !single && (k_reg + KW'(2) <= K_LAST) && (mag(ak2k1) > TOL_V);
  assign xfer      = eig_valid && eig_ready;
  assign more      = k_reg < K_END;
  assign sqrt_last = cnt_reg == CW'(W);

  // Mean/half-difference and discriminant at 2*FRAC fractional bits.
  logic signed [W:0]    sum_ad, dif_ad, m_calc, p_calc;
  logic signed [DW-1:0] p_ext, b_ext, c_ext, disc;
  logic [DW-1:0]        rad_calc;
  always_comb begin
    sum_ad   = {blk_a_reg[W-1], blk_a_reg} + {blk_d_reg[W-1], blk_d_reg};
    dif_ad   = {blk_a_reg[W-1], blk_a_reg} - {blk_d_reg[W-1], blk_d_reg};
    m_calc   = sum_ad >>> 1;
    p_calc   = dif_ad >>> 1;
    p_ext    = DW'(p_calc);
    b_ext    = DW'(blk_b_reg);
    c_ext    = DW'(blk_c_reg);
    disc     = p_ext * p_ext + b_ext * c_ext;
    rad_calc = disc[DW-1] ? -disc : disc;
  end

  // One restoring square-root step: two radicand bits in, one root bit out.
  logic [RW-1:0]       rem_sh, trial, rem_nxt;
  logic                root_bit;
  logic [W:0]          root_nxt;
  logic [W-1:0]        s_sat;
  logic [W+1:0]        s_ext, hi_sum, lo_sum;
  always_comb begin
    rem_sh   = (rem_reg << 2) | RW'(rad_reg[DW-1 -: 2]);
    trial    = RW'({root_reg, 2'b01});
    root_bit = rem_sh >= trial;
    rem_nxt  = root_bit ? rem_sh - trial : rem_sh;
    root_nxt = (root_reg << 1) | (W + 1)'(root_bit);
    s_sat    = (root_nxt[W:W-1] != 2'b00) ? S_MAX : root_nxt[W-1:0];
    s_ext    = {2'b00, s_sat};
    hi_sum   = {m_reg[W], m_reg} + s_ext;
    lo_sum   = {m_reg[W], m_reg} - s_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    state_next = single ? EMIT1 : CALC;
      CALC:    state_next = SQRT;
      SQRT:    if (sqrt_last) state_next = EMIT1;
      EMIT1:   if (xfer) state_next = pair_reg ? EMIT2 : (more ? SCAN : FIN);
      EMIT2:   if (xfer) state_next = more ? SCAN : FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0; k_reg <= '0; idx_reg <= '0; pair_reg <= 1'b0; neg_reg <= 1'b0;
      malformed_reg <= 1'b0; blk_a_reg <= '0; blk_b_reg <= '0; blk_c_reg <= '0;
      blk_d_reg <= '0; m_reg <= '0; rad_reg <= '0; rem_reg <= '0; root_reg <= '0;
      cnt_reg <= '0; eig_re_reg <= '0; eig_im_reg <= '0; re2_reg <= '0; im2_reg <= '0;
      eig_idx_reg <= '0; eig_cplx_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          a_reg <= a_mat; k_reg <= '0; malformed_reg <= 1'b0;
        end
        SCAN: if (single) begin
          eig_re_reg <= akk; eig_im_reg <= '0; eig_cplx_reg <= 1'b0;
          eig_idx_reg <= k_reg[IW-1:0]; pair_reg <= 1'b0; k_reg <= k_reg + KW'(1);
        end else begin
          blk_a_reg <= akk; blk_b_reg <= akk1; blk_c_reg <= ak1k; blk_d_reg <= ak1k1;
          idx_reg <= k_reg[IW-1:0]; pair_reg <= 1'b1; k_reg <= k_reg + KW'(2);
          if (mal_hit) malformed_reg <= 1'b1;
        end
        CALC: begin
          m_reg <= m_calc; neg_reg <= disc[DW-1]; rad_reg <= rad_calc;
          rem_reg <= '0; root_reg <= '0; cnt_reg <= '0;
        end
        SQRT: begin
          rad_reg <= rad_reg << 2; rem_reg <= rem_nxt; root_reg <= root_nxt;
          cnt_reg <= cnt_reg + CW'(1);
          if (sqrt_last) begin
            eig_idx_reg <= idx_reg; eig_cplx_reg <= neg_reg;
            if (neg_reg) begin
              eig_re_reg <= m_reg[W-1:0]; eig_im_reg <= s_sat;
              re2_reg <= m_reg[W-1:0]; im2_reg <= -s_sat;
            end else begin
              eig_re_reg <= sat(hi_sum); eig_im_reg <= '0;
              re2_reg <= sat(lo_sum); im2_reg <= '0;
            end
          end
        end
        EMIT1: if (xfer && pair_reg) begin
          eig_re_reg <= re2_reg; eig_im_reg <= im2_reg; eig_idx_reg <= idx_reg + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy      = state_reg != IDLE;
  assign done      = state_reg == FIN;
  assign eig_valid = (state_reg == EMIT1) || (state_reg == EMIT2);
  assign eig_re    = eig_re_reg;
  assign eig_im    = eig_im_reg;
  assign eig_idx   = eig_idx_reg;
  assign eig_cplx  = eig_cplx_reg;
  assign malformed = malformed_reg;

endmodule

// File: tb/tb_schur_eig_extract.sv
// Directed self-checking bench for schur_eig_extract (N=4, W=16, FRAC=8, TOL=0).
module tb_schur_eig_extract;
  localparam int N = 4;
  localparam int W = 16;

  logic             clk = 1'b0;
  logic             rst, start, eig_ready;
  logic [N*N*W-1:0] a_mat, mat;
  logic             busy, done, eig_valid, eig_cplx, malformed;
  logic [W-1:0]     eig_re, eig_im;
  logic [1:0]       eig_idx;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] got_re [8];
  logic [W-1:0] got_im [8];
  logic [1:0]   got_idx [8];
  logic         got_cplx [8];
  int           n_got, done_cnt;
  bit           timed_out;

  schur_eig_extract #(.N(N), .W(W), .FRAC(8), .TOL(0)) dut (
    .clk(clk), .rst(rst), .start(start), .a_mat(a_mat), .busy(busy), .done(done),
    .eig_valid(eig_valid), .eig_ready(eig_ready), .eig_re(eig_re), .eig_im(eig_im),
    .eig_idx(eig_idx), .eig_cplx(eig_cplx), .malformed(malformed)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_el(input int i, input int j, input logic [W-1:0] v);
    mat[(i*N+j)*W +: W] = v;
  endtask

  task automatic start_pulse();
    a_mat = mat; start = 1'b1;
    step();
    start = 1'b0; a_mat = '0;
  endtask

  task automatic load_diag();
    mat = '0;
    set_el(0, 0, 16'h0200); set_el(1, 1, 16'h0300);
    set_el(2, 2, 16'hFF00); set_el(3, 3, 16'h0500);
  endtask

  task automatic load_cplx();
    mat = '0;
    set_el(0, 0, 16'h0100); set_el(0, 1, 16'hFE00);
    set_el(1, 0, 16'h0100); set_el(1, 1, 16'h0100);
    set_el(2, 2, 16'h0080); set_el(3, 3, 16'h0040);
  endtask

  // Records every handshake until the done pulse, then steps one cycle past it.
  task automatic collect(input int budget);
    n_got = 0; done_cnt = 0; timed_out = 1'b1;
    for (int c = 0; c < 8; c++) begin
      got_re[c] = '0; got_im[c] = '0; got_idx[c] = '0; got_cplx[c] = 1'b0;
    end
    for (int c = 0; c < budget; c++) begin
      if (eig_valid && eig_ready) begin
        if (n_got < 8) begin
          got_re[n_got] = eig_re; got_im[n_got] = eig_im;
          got_idx[n_got] = eig_idx; got_cplx[n_got] = eig_cplx;
        end
        $display("xfer %0d: re=%h im=%h idx=%0d cplx=%0b", n_got, eig_re, eig_im, eig_idx, eig_cplx);
        n_got++;
      end
      if (done) begin
        done_cnt++; timed_out = 1'b0;
        step();
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; eig_ready = 1'b1; a_mat = '0; mat = '0;
    step(); step();
    rst = 1'b0;
    n_checks++;
    if ({busy, done, eig_valid, malformed} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 0000", {busy, done, eig_valid, malformed});
    end
    n_checks++;
    if ({eig_re, eig_im, eig_idx, eig_cplx} !== 35'd0) begin
      n_fail++; $display("FAIL reset_data: got re=%h im=%h idx=%0d cplx=%0b required all 0",
                         eig_re, eig_im, eig_idx, eig_cplx);
    end
  endtask

  task automatic test_diag();
    logic [W-1:0] e_re [4] = '{16'h0200, 16'h0300, 16'hFF00, 16'h0500};
    load_diag();
    start_pulse();
    n_checks++;
    if ({busy, eig_valid} !== 2'b10) begin
      n_fail++; $display("FAIL diag_lat1: busy,valid got %b required 10", {busy, eig_valid});
    end
    step();
    n_checks++;
    if (eig_valid !== 1'b1) begin
      n_fail++; $display("FAIL diag_lat2: valid got %b required 1", eig_valid);
    end
    collect(40);
    n_checks++;
    if (timed_out || n_got != 4 || done_cnt != 1) begin
      n_fail++; $display("FAIL diag_count: got %0d xfers timeout=%0b required 4", n_got, timed_out);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({got_re[i], got_im[i], got_idx[i], got_cplx[i]} !== {e_re[i], 16'h0000, 2'(i), 1'b0}) begin
        n_fail++; $display("FAIL diag_xfer%0d: got re=%h im=%h idx=%0d cplx=%0b required re=%h im=0000 idx=%0d cplx=0",
                           i, got_re[i], got_im[i], got_idx[i], got_cplx[i], e_re[i], i);
      end
    end
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL diag_after_done: busy,done got %b required 00", {busy, done});
    end
  endtask

  task automatic test_complex();
    logic [W-1:0] e_re [4] = '{16'h0100, 16'h0100, 16'h0080, 16'h0040};
    logic [W-1:0] e_im [4] = '{16'h016A, 16'hFE96, 16'h0000, 16'h0000};
    logic         e_cx [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    load_cplx();
    start_pulse();
    for (int c = 0; c < 18; c++) step();
    n_checks++;
    if (eig_valid !== 1'b0) begin
      n_fail++; $display("FAIL cplx_lat_early: valid got %b required 0", eig_valid);
    end
    step();
    n_checks++;
    if (eig_valid !== 1'b1) begin
      n_fail++; $display("FAIL cplx_lat: valid got %b required 1", eig_valid);
    end
    collect(60);
    n_checks++;
    if (timed_out || n_got != 4) begin
      n_fail++; $display("FAIL cplx_count: got %0d xfers timeout=%0b required 4", n_got, timed_out);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({got_re[i], got_im[i], got_idx[i], got_cplx[i]} !== {e_re[i], e_im[i], 2'(i), e_cx[i]}) begin
        n_fail++; $display("FAIL cplx_xfer%0d: got re=%h im=%h idx=%0d cplx=%0b required re=%h im=%h idx=%0d cplx=%0b",
                           i, got_re[i], got_im[i], got_idx[i], got_cplx[i], e_re[i], e_im[i], i, e_cx[i]);
      end
    end
  endtask

  task automatic test_real_pair();
    logic [W-1:0] e_re [4] = '{16'h0100, 16'h0200, 16'h0400, 16'h0100};
    mat = '0;
    set_el(0, 0, 16'h0100); set_el(1, 1, 16'h0200);
    set_el(2, 2, 16'h0300); set_el(2, 3, 16'h0100);
    set_el(3, 2, 16'h0200); set_el(3, 3, 16'h0200);
    start_pulse();
    collect(60);
    n_checks++;
    if (timed_out || n_got != 4 || malformed !== 1'b0) begin
      n_fail++; $display("FAIL real_count: got %0d xfers timeout=%0b malformed=%0b required 4,0,0",
                         n_got, timed_out, malformed);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({got_re[i], got_im[i], got_idx[i], got_cplx[i]} !== {e_re[i], 16'h0000, 2'(i), 1'b0}) begin
        n_fail++; $display("FAIL real_xfer%0d: got re=%h im=%h idx=%0d cplx=%0b required re=%h im=0000 idx=%0d cplx=0",
                           i, got_re[i], got_im[i], got_idx[i], got_cplx[i], e_re[i], i);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] e_re [4] = '{16'h0200, 16'h0300, 16'hFF00, 16'h0500};
    eig_ready = 1'b0;
    load_diag();
    start_pulse();
    for (int c = 0; c < 10; c++) begin
      if (eig_valid) break;
      step();
    end
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if ({eig_valid, eig_re, eig_im, eig_idx, eig_cplx} !== {1'b1, 16'h0200, 16'h0000, 2'd0, 1'b0}) begin
        n_fail++; $display("FAIL bp_hold%0d: got valid=%0b re=%h im=%h idx=%0d cplx=%0b required 1,0200,0000,0,0",
                           c, eig_valid, eig_re, eig_im, eig_idx, eig_cplx);
      end
      step();
    end
    eig_ready = 1'b1;
    collect(40);
    n_checks++;
    if (timed_out || n_got != 4) begin
      n_fail++; $display("FAIL bp_count: got %0d xfers timeout=%0b required 4", n_got, timed_out);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({got_re[i], got_idx[i]} !== {e_re[i], 2'(i)}) begin
        n_fail++; $display("FAIL bp_xfer%0d: got re=%h idx=%0d required re=%h idx=%0d",
                           i, got_re[i], got_idx[i], e_re[i], i);
      end
    end
  endtask

  task automatic test_malformed_busy();
    logic [W-1:0] e_re [4] = '{16'h0200, 16'h0100, 16'h0300, 16'h0400};
    mat = '0;
    set_el(0, 0, 16'h0100); set_el(1, 1, 16'h0200);
    set_el(2, 2, 16'h0300); set_el(3, 3, 16'h0400);
    set_el(1, 0, 16'h0100); set_el(2, 1, 16'h0100);
    start_pulse();
    step();
    a_mat = '0; start = 1'b1;
    step();
    start = 1'b0;
    collect(80);
    n_checks++;
    if (malformed !== 1'b1) begin
      n_fail++; $display("FAIL mal_flag: got %0b required 1", malformed);
    end
    n_checks++;
    if (timed_out || n_got != 4 || done_cnt != 1) begin
      n_fail++; $display("FAIL mal_count: got %0d xfers done=%0d timeout=%0b required 4,1",
                         n_got, done_cnt, timed_out);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({got_re[i], got_im[i], got_idx[i], got_cplx[i]} !== {e_re[i], 16'h0000, 2'(i), 1'b0}) begin
        n_fail++; $display("FAIL mal_xfer%0d: got re=%h im=%h idx=%0d cplx=%0b required re=%h im=0000 idx=%0d cplx=0",
                           i, got_re[i], got_im[i], got_idx[i], got_cplx[i], e_re[i], i);
      end
    end
  endtask

  task automatic test_reset_mid();
    int vcnt;
    logic [W-1:0] e_re [4] = '{16'h0100, 16'h0100, 16'h0080, 16'h0040};
    logic [W-1:0] e_im [4] = '{16'h016A, 16'hFE96, 16'h0000, 16'h0000};
    load_cplx();
    start_pulse();
    n_checks++;
    if (malformed !== 1'b0) begin
      n_fail++; $display("FAIL rst_mal_clear: got %0b required 0", malformed);
    end
    for (int c = 0; c < 6; c++) step();
    rst = 1'b1;
    step();
    n_checks++;
    if ({busy, done, eig_valid, malformed, eig_re, eig_im, eig_idx, eig_cplx} !== 39'd0) begin
      n_fail++; $display("FAIL rst_mid: got busy=%0b done=%0b valid=%0b re=%h im=%h idx=%0d cplx=%0b required all 0",
                         busy, done, eig_valid, eig_re, eig_im, eig_idx, eig_cplx);
    end
    rst = 1'b0;
    vcnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (eig_valid || busy) vcnt++;
      step();
    end
    n_checks++;
    if (vcnt != 0) begin
      n_fail++; $display("FAIL rst_quiet: active cycles got %0d required 0", vcnt);
    end
    start_pulse();
    collect(60);
    n_checks++;
    if (timed_out || n_got != 4) begin
      n_fail++; $display("FAIL rst_restart_count: got %0d xfers timeout=%0b required 4", n_got, timed_out);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({got_re[i], got_im[i], got_idx[i]} !== {e_re[i], e_im[i], 2'(i)}) begin
        n_fail++; $display("FAIL rst_restart_xfer%0d: got re=%h im=%h idx=%0d required re=%h im=%h idx=%0d",
                           i, got_re[i], got_im[i], got_idx[i], e_re[i], e_im[i], i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_diag();
    test_complex();
    test_real_pair();
    test_backpressure();
    test_malformed_busy();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
